// File: rtl/aes_vec_seq_pkg.sv
// Shared types and constants for the AES known-answer vector sequencer.
package aes_vec_seq_pkg;

    localparam int AES_W = 128;

    localparam logic [1:0] KS128 = 2'b00;
    localparam logic [1:0] KS192 = 2'b01;
    localparam logic [1:0] KS256 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_KEY,
        S_ISSUE,
        S_WAIT_ENC,
        S_ISSUE_DEC,
        S_WAIT_DEC,
        S_CHECK,
        S_DONE
    } state_e;

    // Both 2'b10 and 2'b11 select a 256-bit key; store a single canonical code.
    function automatic logic [1:0] norm_ks(input logic [1:0] ks);
        case (ks)
            2'b00:   return KS128;
            2'b01:   return KS192;
            default: return KS256;
        endcase
    endfunction

endpackage

// File: rtl/aes_vec_cmp.sv
// Registered 128-bit equality check; flag holds until cleared or reloaded.
module aes_vec_cmp
    import aes_vec_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [AES_W-1:0] a,
    input  logic [AES_W-1:0] b,
    output logic             mismatch
);

    logic mismatch_d, mismatch_q;

    always_comb begin
        mismatch_d = mismatch_q;
        if (clr) begin
            mismatch_d = 1'b0;
        end else if (en) begin
            mismatch_d = (a != b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;

endmodule

// File: rtl/aes_vec_seq.sv
// Runs a stored table of AES known-answer vectors through an external engine
// and accumulates pass/fail status, optionally round-tripping via the decryptor.
module aes_vec_seq
    import aes_vec_seq_pkg::*;
#(
    parameter int NVEC     = 4,
    parameter int TMO      = 64,
    parameter bit LOOPBACK = 1'b0,
    localparam int IW      = (NVEC > 1) ? $clog2(NVEC) : 1
) (
    input  logic             eph1,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [AES_W-1:0] wr_plain,
    input  logic [AES_W-1:0] wr_expect,
    input  logic [1:0]       wr_key_size,
    input  logic             start,
    input  logic             key_ready,
    output logic             enc_ready,
    output logic [AES_W-1:0] enc_plain,
    output logic [1:0]       enc_key_size,
    input  logic             enc_done,
    input  logic [AES_W-1:0] enc_out,
    output logic             dec_ready,
    output logic [AES_W-1:0] dec_cipher,
    input  logic             dec_done,
    input  logic [AES_W-1:0] dec_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       fail_cnt,
    output logic [3:0]       first_fail,
    output logic             tmo_err
);

    logic [AES_W-1:0] plain_tbl  [NVEC];
    logic [AES_W-1:0] expect_tbl [NVEC];
    logic [1:0]       ks_tbl     [NVEC];

    state_e           state_d, state_q;
    logic [IW-1:0]    idx_d, idx_q;
    logic [7:0]       tmo_cnt_d, tmo_cnt_q;
    logic             tmo_err_d, tmo_err_q;
    logic [4:0]       fail_cnt_d, fail_cnt_q;
    logic [3:0]       first_fail_d, first_fail_q;
    logic [AES_W-1:0] enc_plain_d, enc_plain_q;
    logic [1:0]       enc_ks_d, enc_ks_q;
    logic [AES_W-1:0] enc_cap_d, enc_cap_q;
    logic             enc_mis, dec_mis, fail_ev, adv, tmo_hit, last_vec, wr_ok;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // Table is plain storage: no reset, writable only between runs.
    assign wr_ok = wr_en && !busy && (32'(wr_idx) < NVEC);

    always_ff @(posedge eph1) begin
        if (wr_ok) begin
            plain_tbl[wr_idx]  <= wr_plain;
            expect_tbl[wr_idx] <= wr_expect;
            ks_tbl[wr_idx]     <= norm_ks(wr_key_size);
        end
    end

    aes_vec_cmp u_cmp_enc (
        .clk      (eph1),
        .rst_n    (reset_n),
        .clr      (state_q == S_ISSUE),
        .en       ((state_q == S_WAIT_ENC) && enc_done),
        .a        (enc_out),
        .b        (expect_tbl[idx_q]),
        .mismatch (enc_mis)
    );

    aes_vec_cmp u_cmp_dec (
        .clk      (eph1),
        .rst_n    (reset_n),
        .clr      (state_q == S_ISSUE),
        .en       (LOOPBACK && (state_q == S_WAIT_DEC) && dec_done),
        .a        (dec_out),
        .b        (plain_tbl[idx_q]),
        .mismatch (dec_mis)
    );

    assign tmo_hit  = (tmo_cnt_q == 8'(TMO - 1));
    assign last_vec = (32'(idx_q) == NVEC - 1);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        tmo_cnt_d    = tmo_cnt_q;
        tmo_err_d    = tmo_err_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        enc_plain_d  = enc_plain_q;
        enc_ks_d     = enc_ks_q;
        enc_cap_d    = enc_cap_q;
        fail_ev      = 1'b0;
        adv          = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_WAIT_KEY;
                    idx_d        = '0;
                    tmo_err_d    = 1'b0;
                    fail_cnt_d   = '0;
                    first_fail_d = '0;
                end
            end
            S_WAIT_KEY: if (key_ready) state_d = S_ISSUE;
            S_ISSUE: begin
                state_d   = S_WAIT_ENC;
                tmo_cnt_d = '0;
            end
            S_WAIT_ENC: begin
                if (enc_done) begin
                    enc_cap_d = enc_out;
                    state_d   = LOOPBACK ? S_ISSUE_DEC : S_CHECK;
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    fail_ev   = 1'b1;
                    adv       = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_ISSUE_DEC: begin
                state_d   = S_WAIT_DEC;
                tmo_cnt_d = '0;
            end
            S_WAIT_DEC: begin
                if (dec_done) begin
                    state_d = S_CHECK;
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    fail_ev   = 1'b1;
                    adv       = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                fail_ev = enc_mis || dec_mis;
                adv     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A timed-out vector skips CHECK but advances exactly as CHECK would.
        if (adv) begin
            if (last_vec) begin
                state_d = S_DONE;
            end else begin
                idx_d   = idx_q + IW'(1);
                state_d = key_ready ? S_ISSUE : S_WAIT_KEY;
            end
        end

        if (fail_ev) begin
            if (fail_cnt_q == 5'd0) first_fail_d = 4'(idx_q);
            fail_cnt_d = sat_inc(fail_cnt_q);
        end

        if (state_d == S_ISSUE) begin
            enc_plain_d = plain_tbl[idx_d];
            enc_ks_d    = ks_tbl[idx_d];
        end
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            tmo_cnt_q    <= '0;
            tmo_err_q    <= 1'b0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            enc_plain_q  <= '0;
            enc_ks_q     <= '0;
            enc_cap_q    <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            tmo_cnt_q    <= tmo_cnt_d;
            tmo_err_q    <= tmo_err_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            enc_plain_q  <= enc_plain_d;
            enc_ks_q     <= enc_ks_d;
            enc_cap_q    <= enc_cap_d;
        end
    end

    assign busy         = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done         = (state_q == S_DONE);
    assign pass         = done && (fail_cnt_q == 5'd0) && !tmo_err_q;
    assign enc_ready    = (state_q == S_ISSUE);
    assign dec_ready    = LOOPBACK && (state_q == S_ISSUE_DEC);
    assign enc_plain    = enc_plain_q;
    assign enc_key_size = enc_ks_q;
    assign dec_cipher   = LOOPBACK ? enc_cap_q : '0;
    assign fail_cnt     = fail_cnt_q;
    assign first_fail   = first_fail_q;
    assign tmo_err      = tmo_err_q;

endmodule

// File: tb/tb_aes_vec_seq.sv
// Randomised and directed checks of aes_vec_seq against a table-level reference model.
module tb_aes_vec_seq;

    localparam bit [127:0] KC = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [2:0]   wr_en, start;
    logic [1:0]   wr_idx, wr_ks;
    logic [127:0] wr_plain, wr_expect;
    logic         key_ready;

    logic         er[3], dr[3], bsy[3], dn[3], ps[3], te[3];
    logic [127:0] ep[3], dc[3];
    logic [1:0]   eks[3];
    logic [4:0]   fc[3];
    logic [3:0]   ff[3];
    bit           edn[3];
    bit   [127:0] eout[3];
    bit           dd;
    bit   [127:0] dout;

    aes_vec_seq #(.NVEC(4), .TMO(8), .LOOPBACK(1'b0)) u_d0 (
        .eph1(clk), .reset_n(rst_n), .wr_en(wr_en[0]), .wr_idx(wr_idx), .wr_plain(wr_plain),
        .wr_expect(wr_expect), .wr_key_size(wr_ks), .start(start[0]), .key_ready(key_ready),
        .enc_ready(er[0]), .enc_plain(ep[0]), .enc_key_size(eks[0]), .enc_done(edn[0]),
        .enc_out(eout[0]), .dec_ready(dr[0]), .dec_cipher(dc[0]), .dec_done(1'b0),
        .dec_out(128'd0), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .fail_cnt(fc[0]),
        .first_fail(ff[0]), .tmo_err(te[0]));

    aes_vec_seq #(.NVEC(4), .TMO(16), .LOOPBACK(1'b1)) u_d1 (
        .eph1(clk), .reset_n(rst_n), .wr_en(wr_en[1]), .wr_idx(wr_idx), .wr_plain(wr_plain),
        .wr_expect(wr_expect), .wr_key_size(wr_ks), .start(start[1]), .key_ready(key_ready),
        .enc_ready(er[1]), .enc_plain(ep[1]), .enc_key_size(eks[1]), .enc_done(edn[1]),
        .enc_out(eout[1]), .dec_ready(dr[1]), .dec_cipher(dc[1]), .dec_done(dd),
        .dec_out(dout), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .fail_cnt(fc[1]),
        .first_fail(ff[1]), .tmo_err(te[1]));

    aes_vec_seq #(.NVEC(1), .TMO(64), .LOOPBACK(1'b0)) u_d2 (
        .eph1(clk), .reset_n(rst_n), .wr_en(wr_en[2]), .wr_idx(wr_idx[0]), .wr_plain(wr_plain),
        .wr_expect(wr_expect), .wr_key_size(wr_ks), .start(start[2]), .key_ready(key_ready),
        .enc_ready(er[2]), .enc_plain(ep[2]), .enc_key_size(eks[2]), .enc_done(edn[2]),
        .enc_out(eout[2]), .dec_ready(dr[2]), .dec_cipher(dc[2]), .dec_done(1'b0),
        .dec_out(128'd0), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .fail_cnt(fc[2]),
        .first_fail(ff[2]), .tmo_err(te[2]));

    // Stand-in cipher: any bijection serves, the sequencer only compares values.
    function automatic bit [127:0] f(input bit [127:0] x);
        return {x[126:0], x[127]} ^ KC;
    endfunction
    function automatic bit [127:0] finv(input bit [127:0] y);
        bit [127:0] t;
        t = y ^ KC;
        return {t[0], t[127:1]};
    endfunction

    int         lat[3];
    bit         mute[3];
    int         ecnt[3];
    bit [127:0] eheld[3];
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            edn[k] <= 1'b0;
            if (ecnt[k] > 0) begin
                ecnt[k] <= ecnt[k] - 1;
                if (ecnt[k] == 1) begin
                    edn[k]  <= 1'b1;
                    eout[k] <= f(eheld[k]);
                end
            end
            if (er[k] && !mute[k]) begin
                eheld[k] <= ep[k];
                if (lat[k] == 0) begin
                    edn[k]  <= 1'b1;
                    eout[k] <= f(ep[k]);
                    ecnt[k] <= 0;
                end else begin
                    ecnt[k] <= lat[k];
                end
            end
        end
    end

    int         dlat, dcnt;
    bit         dbad;
    bit [127:0] dheld;
    always @(posedge clk) begin
        dd <= 1'b0;
        if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) begin
                dd   <= 1'b1;
                dout <= finv(dheld) ^ {127'd0, dbad};
            end
        end
        if (dr[1]) begin
            dheld <= dc[1];
            if (dlat == 0) begin
                dd   <= 1'b1;
                dout <= finv(dc[1]) ^ {127'd0, dbad};
                dcnt <= 0;
            end else begin
                dcnt <= dlat;
            end
        end
    end

    int           cyc, npulse_e[3], npulse_d, last_t[3], prev_t[3];
    logic [129:0] iss[3][$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (er[k]) begin
                npulse_e[k] <= npulse_e[k] + 1;
                prev_t[k]   <= last_t[k];
                last_t[k]   <= cyc;
                iss[k].push_back({eks[k], ep[k]});
            end
        end
        if (dr[1]) npulse_d <= npulse_d + 1;
    end

    int         total = 0, bad = 0;
    int         nv[3] = '{4, 4, 1};
    bit         running[3];
    bit [127:0] mp[3][4], mx[3][4];
    bit [1:0]   mk[3][4];
    int         base_e[3], base_i[3], base_d;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Table write; the model only records what the block is supposed to accept.
    task automatic wr(input int k, input int idx, input bit [127:0] p, input bit [127:0] e,
                      input bit [1:0] ks);
        wr_en[k] = 1'b1; wr_idx = 2'(idx); wr_plain = p; wr_expect = e; wr_ks = ks;
        tick(1);
        wr_en[k] = 1'b0;
        if (!running[k] && idx < nv[k]) begin
            mp[k][idx] = p; mx[k][idx] = e; mk[k][idx] = ks[1] ? 2'b10 : ks;
        end
    endtask

    task automatic fill(input int k, input bit corrupt);
        bit [127:0] p, e;
        for (int i = 0; i < nv[k]; i++) begin
            p = {$urandom, $urandom, $urandom, $urandom};
            e = f(p);
            if (corrupt && $urandom_range(0, 2) == 0) e[$urandom_range(0, 127)] ^= 1'b1;
            wr(k, i, p, e, 2'($urandom_range(0, 3)));
        end
    endtask

    task automatic model(input int k, input bit tmo_all, output logic [4:0] efc,
                         output logic [3:0] eff, output logic eps);
        int n = 0;
        eff = '0;
        for (int i = 0; i < nv[k]; i++) begin
            if (tmo_all || mx[k][i] != f(mp[k][i]) || (k == 1 && dbad)) begin
                if (n == 0) eff = 4'(i);
                n++;
            end
        end
        efc = (n > 31) ? 5'd31 : 5'(n);
        eps = (n == 0) && !tmo_all;
    endtask

    // Start a run, then poke start and a table write while busy; both must be ignored.
    task automatic go(input int k);
        base_e[k] = npulse_e[k]; base_i[k] = iss[k].size(); base_d = npulse_d;
        start[k] = 1'b1; tick(1); start[k] = 1'b0;
        running[k] = 1'b1;
        start[k] = 1'b1; wr_en[k] = 1'b1; wr_idx = 2'(nv[k] - 1);
        wr_plain = ~mp[k][nv[k] - 1]; wr_expect = ~mx[k][nv[k] - 1]; wr_ks = 2'b01;
        tick(1);
        start[k] = 1'b0; wr_en[k] = 1'b0;
    endtask

    task automatic finish(input int k, input int budget, input bit tmo_all);
        logic [4:0] efc;
        logic [3:0] eff;
        logic       eps;
        int         i = 0;
        while (!dn[k] && i < budget) begin tick(1); i++; end
        running[k] = 1'b0;
        model(k, tmo_all, efc, eff, eps);
        chk($sformatf("d%0d done", k), dn[k], 1'b1);
        chk($sformatf("d%0d busy", k), bsy[k], 1'b0);
        chk($sformatf("d%0d pass", k), ps[k], eps);
        chk($sformatf("d%0d fail_cnt", k), fc[k], efc);
        chk($sformatf("d%0d first_fail", k), ff[k], eff);
        chk($sformatf("d%0d tmo_err", k), te[k], tmo_all);
        chk($sformatf("d%0d enc pulses", k), npulse_e[k] - base_e[k], nv[k]);
        for (int j = 0; j < nv[k]; j++)
            chk($sformatf("d%0d issued vec%0d", k, j),
                (base_i[k] + j < iss[k].size()) ? iss[k][base_i[k] + j] : 130'bx,
                {mk[k][j], mp[k][j]});
        if (k == 1) chk("d1 dec pulses", npulse_d - base_d, nv[1]);
    endtask

    task automatic wait_issue(input int k, input int budget);
        int i = 0;
        while (!er[k] && i < budget) begin tick(1); i++; end
        chk($sformatf("d%0d issue seen", k), er[k], 1'b1);
    endtask

    initial begin
        bit [127:0] p1;
        rst_n = 1'b0; wr_en = '0; start = '0; wr_idx = '0; wr_ks = '0;
        wr_plain = '0; wr_expect = '0; key_ready = 1'b1; dlat = 0; dbad = 1'b0;
        lat = '{0, 0, 0}; mute = '{0, 0, 0};
        tick(2);
        chk("rst busy", bsy[0], 1'b0);
        chk("rst done", dn[0], 1'b0);
        chk("rst pass", ps[0], 1'b0);
        chk("rst enc_ready", er[0], 1'b0);
        chk("rst enc_plain", ep[0], 128'd0);
        chk("rst fail_cnt", fc[0], 5'd0);
        chk("rst tmo_err", te[0], 1'b0);
        rst_n = 1'b1;
        tick(1);

        // Single vector, 14-cycle engine, 256-bit key; an out-of-range write is dropped.
        p1 = 128'h27ECB2E3A5EE3894885B5289307400E3;
        wr(2, 0, p1, f(p1), 2'b10);
        wr(2, 1, ~p1, p1, 2'b00);
        lat[2] = 14;
        go(2);
        finish(2, 200, 1'b0);
        chk("d2 key size", eks[2], 2'b10);

        // All-good table with a zero-latency engine: back-to-back spacing of three.
        fill(0, 1'b0);
        go(0);
        finish(0, 200, 1'b0);
        chk("d0 issue spacing", last_t[0] - prev_t[0], 3);

        // Vector 2 expect off by bit 0.
        wr(0, 2, mp[0][2], mx[0][2] ^ 128'd1, 2'b00);
        go(0);
        finish(0, 200, 1'b0);

        for (int r = 0; r < 4; r++) begin
            fill(0, 1'b1);
            lat[0] = $urandom_range(0, 4);
            go(0);
            finish(0, 300, 1'b0);
        end

        // Key not ready for ten cycles after start.
        fill(0, 1'b0);
        lat[0] = 1;
        key_ready = 1'b0;
        go(0);
        tick(8);
        chk("keyhold no issue", npulse_e[0] - base_e[0], 0);
        chk("keyhold busy", bsy[0], 1'b1);
        key_ready = 1'b1;
        tick(1);
        chk("keyhold first issue", er[0], 1'b1);
        finish(0, 200, 1'b0);

        // Silent encryptor: every vector times out after eight waiting cycles.
        mute[0] = 1'b1;
        go(0);
        wait_issue(0, 20);
        tick(8);
        chk("tmo not early", te[0], 1'b0);
        tick(1);
        chk("tmo set", te[0], 1'b1);
        finish(0, 300, 1'b1);
        mute[0] = 1'b0;

        // Loopback, zero latency: spacing of five, one dec pulse per vector.
        fill(1, 1'b0);
        lat[1] = 0; dlat = 0;
        go(1);
        finish(1, 200, 1'b0);
        chk("d1 issue spacing", last_t[1] - prev_t[1], 5);

        // Key drops during vector 0: it completes, then the sequencer parks.
        lat[1] = 3; dlat = 2;
        go(1);
        key_ready = 1'b0;
        tick(15);
        chk("keydrop one issue", npulse_e[1] - base_e[1], 1);
        chk("keydrop busy", bsy[1], 1'b1);
        key_ready = 1'b1;
        finish(1, 200, 1'b0);

        // Decryptor returns a wrong plaintext for every vector.
        dbad = 1'b1; lat[1] = 0; dlat = 0;
        go(1);
        finish(1, 200, 1'b0);
        dbad = 1'b0;

        // Asynchronous reset while waiting on the encryptor.
        fill(0, 1'b0);
        lat[0] = 6;
        go(0);
        wait_issue(0, 20);
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst busy", bsy[0], 1'b0);
        chk("arst enc_plain", ep[0], 128'd0);
        chk("arst enc_key_size", eks[0], 2'b00);
        chk("arst d1 done", dn[1], 1'b0);
        chk("arst d1 fail_cnt", fc[1], 5'd0);
        chk("arst d1 first_fail", ff[1], 4'd0);
        chk("arst d1 dec_cipher", dc[1], 128'd0);
        chk("arst d1 pass", ps[1], 1'b0);
        tick(2);
        rst_n = 1'b1;
        running = '{0, 0, 0};
        lat[0] = 0;
        tick(1);
        go(0);
        finish(0, 200, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_vec_seq.md
AES_VEC_SEQ -- requirements
Module: aes_vec_seq

Interface
REQ-001 Parameter NVEC, default 4: number of stored test vectors, 1..16.
REQ-002 Parameter TMO, default 64: cycle limit for each wait on the AES engine, 2..255.
REQ-003 Parameter LOOPBACK, default 0: 1 sends each ciphertext through the decryptor and checks that plaintext returns.
REQ-004 eph1  in  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_en  in  1  write one vector-table entry this cycle.
REQ-007 wr_idx  in  clog2(NVEC) (min 1)  entry index for the write.
REQ-008 wr_plain  in  128  plaintext for the entry.
REQ-009 wr_expect  in  128  expected ciphertext for the entry.
REQ-010 wr_key_size  in  2  key size: 00 = 128, 01 = 192, 1x = 256.
REQ-011 start  in  1  begin a run, one-cycle pulse.
REQ-012 key_ready  in  1  key expansion valid (level).
REQ-013 enc_ready  out  1  one-cycle issue pulse to the encryptor.
REQ-014 enc_plain  out  128  plaintext held stable while the encryptor is busy.
REQ-015 enc_key_size  out  2  key size held with enc_plain.
REQ-016 enc_done, enc_out  in  1, 128  encryptor completion pulse and result.
REQ-017 dec_ready, dec_cipher  out  1, 128  decrypt issue pulse and ciphertext; tied to 0 when LOOPBACK = 0.
REQ-018 dec_done, dec_out  in  1, 128  decryptor completion pulse and result.
REQ-019 busy, done, pass  out  1 each  run active; run finished (sticky); no failures (valid when done).
REQ-020 fail_cnt  out  5  mismatch count, saturating at 31.
REQ-021 first_fail  out  4  index of the first failing vector.
REQ-022 tmo_err  out  1  sticky flag: a timeout occurred.

Function
REQ-023 FSM states and transitions:
- IDLE -> WAIT_KEY on start.
- WAIT_KEY -> ISSUE when key_ready = 1.
- ISSUE -> WAIT_ENC.
- WAIT_ENC -> CHECK on enc_done when LOOPBACK = 0.
- WAIT_ENC -> ISSUE_DEC on enc_done when LOOPBACK = 1.
- ISSUE_DEC -> WAIT_DEC.
- WAIT_DEC -> CHECK on dec_done.
- CHECK -> ISSUE for the next vector, or DONE after vector NVEC-1.
- DONE -> WAIT_KEY on start.
REQ-024 enc_ready is high only in ISSUE; dec_ready is high only in ISSUE_DEC; each is exactly one cycle per vector.
REQ-025 enc_out is captured in the enc_done cycle. dec_cipher equals that captured value.
REQ-026 Checks:
- CHECK compares the captured enc_out with expect[idx].
- With LOOPBACK = 1 it also compares dec_out with plain[idx].
- Any mismatch increments fail_cnt.
- The first mismatch loads first_fail.
REQ-027 Wait timeout: the counter clears on entry to WAIT_ENC or WAIT_DEC. When it reaches TMO without the expected done pulse, tmo_err sets, the vector counts as a failure, and the FSM continues at CHECK's successor.
REQ-028 enc_done or dec_done outside the matching wait state is ignored.
REQ-029 If key_ready drops mid-run, the in-flight vector completes and the FSM waits in WAIT_KEY before the next ISSUE.
REQ-030 start while busy is ignored. start in DONE clears done, pass, fail_cnt, first_fail and tmo_err, then reruns from vector 0.
REQ-031 Table writes succeed only while busy = 0. wr_idx >= NVEC is dropped.
REQ-032 pass = done & (fail_cnt == 0) & ~tmo_err.
REQ-033 Minimum latency per vector, with a zero-latency engine: 3 cycles when LOOPBACK = 0, 5 cycles when LOOPBACK = 1.

Reset
REQ-034 reset_n low forces, asynchronously, even mid-run:
- FSM to IDLE; vector index to 0.
- All outputs to 0: busy, done, pass, enc_ready, dec_ready, enc_plain, enc_key_size, dec_cipher, fail_cnt, first_fail, tmo_err.
REQ-035 Vector table contents are not reset.

Structure
REQ-036 The shared package holds:
- the FSM state enum;
- key-size encodings KS128, KS192 and KS256;
- the width constant AES_W = 128.
REQ-037 One sub-module, aes_vec_cmp: registered 128-bit compare with a mismatch flag, reused for the encrypt and decrypt checks.

Verification
REQ-038 Scenario 1, LOOPBACK = 0, NVEC = 1: vector plain 27ECB2E3A5EE3894885B5289307400E3, key_size 10. Model returns the matching expect value after 14 cycles -> done = 1, pass = 1, fail_cnt = 0.
REQ-039 Scenario 2, NVEC = 4: vector 2 expect corrupted in bit 0 -> fail_cnt = 1, first_fail = 2, pass = 0.
REQ-040 Scenario 3, TMO = 8: model never asserts enc_done -> tmo_err = 1 after 8 cycles; run still reaches done.
REQ-041 Scenario 4, LOOPBACK = 1: decryptor echoes plain -> pass = 1; exactly NVEC pulses on each of enc_ready and dec_ready.
REQ-042 Scenario 5: key_ready held low for 10 cycles after start -> no enc_ready during the hold; first enc_ready one cycle after key_ready rises.
REQ-043 Scenario 6: reset_n pulsed low in WAIT_ENC -> all outputs 0 at once; new start reruns from vector 0 with a clean pass.
